// File: rtl/moving_avg_pkg.sv
// Shared types and helpers for the streaming moving-average filter.
package moving_avg_pkg;

  typedef enum logic [1:0] {CLEAR, FILL, RUN} state_e;

  function automatic int calc_acc_w(input int data_w, input int max_log2_n);
    return data_w + max_log2_n;
  endfunction

  function automatic int calc_depth(input int max_log2_n);
    return 1 << max_log2_n;
  endfunction

  // Two's complement -> offset binary: invert the MSB of a w-bit value.
  function automatic logic [63:0] to_offset_bin(input logic [63:0] v, input int w);
    logic [63:0] r;
    r        = v;
    r[w-1]   = ~r[w-1];
    return r;
  endfunction

endpackage

// File: rtl/sample_ring_buf.sv
// Sample history RAM: one write port, one registered read port.
// A same-cycle write to the read address is forwarded (write-first).
module sample_ring_buf #(
  parameter  int DEPTH  = 128,
  parameter  int DATA_W = 24,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_d, rdata_q;

  // Forwarding matters for N=1, where the next subtract needs the sample written now.
  always_comb rdata_d = (i_we && (i_waddr == i_raddr)) ? i_wdata : mem[i_raddr];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    rdata_q <= rdata_d;
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/moving_avg_stream.sv
// Streaming moving average over a runtime power-of-two window with
// add-new/subtract-oldest running sum and an AXI-Stream output register.
module moving_avg_stream
  import moving_avg_pkg::*;
#(
  parameter int DATA_W     = 24,
  parameter int MAX_LOG2_N = 7,
  parameter int OUT_W      = 32,
  parameter int SIGNED_OUT = 0
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [DATA_W-1:0]                 i_adc_data,
  input  logic                              i_adc_valid,
  input  logic [$clog2(MAX_LOG2_N+1)-1:0]   i_log2_n,
  input  logic                              i_clear,
  output logic [OUT_W-1:0]                  m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              o_primed,
  output logic                              o_overrun
);

  localparam int ACC_W = calc_acc_w(DATA_W, MAX_LOG2_N);
  localparam int DEPTH = calc_depth(MAX_LOG2_N);
  localparam int AW    = MAX_LOG2_N;
  localparam int LW    = $clog2(MAX_LOG2_N+1);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [AW-1:0]     ptr_q, ptr_d, fill_q, fill_d;
  logic [LW-1:0]     log2_q, log2_d, log2_eff;
  logic              primed_q, primed_d, emit_q, emit_d;
  logic              tvalid_q, tvalid_d, ovr_q, ovr_d;
  logic [OUT_W-1:0]  tdata_q, tdata_d;

  logic                     clr, we;
  logic [AW:0]              n_w;
  logic [AW-1:0]            nm1, rd_addr;
  logic [DATA_W-1:0]        x_fmt, old;
  logic signed [DATA_W:0]   x_sx, old_sx;
  logic [ACC_W-1:0]         x_ext, old_ext, shr;
  logic signed [ACC_W:0]    shr_sx;

  sample_ring_buf #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_ring (
    .i_clk   (i_clk),
    .i_we    (we),
    .i_waddr (ptr_q),
    .i_wdata (x_fmt),
    .i_raddr (rd_addr),
    .o_rdata (old)
  );

  // Sample formatting and sign/zero extension into the accumulator domain.
  always_comb begin
    x_fmt   = (SIGNED_OUT != 0) ? i_adc_data
                                : DATA_W'(to_offset_bin(64'(i_adc_data), DATA_W));
    x_sx    = {(SIGNED_OUT != 0) & x_fmt[DATA_W-1], x_fmt};
    old_sx  = {(SIGNED_OUT != 0) & old[DATA_W-1], old};
    x_ext   = ACC_W'(x_sx);
    old_ext = ACC_W'(old_sx);
    if (SIGNED_OUT != 0) shr = $signed(acc_q) >>> log2_q;
    else                 shr = acc_q >> log2_q;
    shr_sx  = {(SIGNED_OUT != 0) & shr[ACC_W-1], shr};
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    ptr_d    = ptr_q;
    fill_d   = fill_q;
    primed_d = primed_q;
    emit_d   = 1'b0;
    we       = 1'b0;
    log2_eff = (i_log2_n > LW'(MAX_LOG2_N)) ? LW'(MAX_LOG2_N) : i_log2_n;
    log2_d   = log2_eff;
    clr      = i_clear || (log2_eff != log2_q);
    n_w      = (AW+1)'(1) << log2_q;
    nm1      = AW'(n_w - (AW+1)'(1));
    if (clr) begin
      state_d  = CLEAR;
      acc_d    = '0;
      ptr_d    = '0;
      fill_d   = '0;
      primed_d = 1'b0;
    end else begin
      unique case (state_q)
        CLEAR: begin
          state_d  = FILL;
          acc_d    = '0;
          ptr_d    = '0;
          fill_d   = '0;
          primed_d = 1'b0;
        end
        FILL: if (i_adc_valid) begin
          we     = 1'b1;
          ptr_d  = ptr_q + AW'(1);
          fill_d = fill_q + AW'(1);
          acc_d  = acc_q + x_ext;
          if (fill_q == nm1) begin
            state_d  = RUN;
            primed_d = 1'b1;
            emit_d   = 1'b1;
          end
        end
        RUN: if (i_adc_valid) begin
          we     = 1'b1;
          ptr_d  = ptr_q + AW'(1);
          acc_d  = acc_q + x_ext - old_ext;
          emit_d = 1'b1;
        end
        default: state_d = CLEAR;
      endcase
    end
    // Registered read: address the oldest sample relative to the next pointer.
    rd_addr = ptr_d - AW'(n_w);
  end

  // Output register: a new result always overwrites; losing an unread one is an overrun.
  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    ovr_d    = ovr_q;
    if (clr || state_q == CLEAR) begin
      tvalid_d = 1'b0;
      if (i_clear) ovr_d = 1'b0;
    end else if (emit_q) begin
      tdata_d  = OUT_W'(shr_sx);
      tvalid_d = 1'b1;
      if (tvalid_q && !m_axis_tready) ovr_d = 1'b1;
    end else if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q  <= CLEAR;
      acc_q    <= '0;
      ptr_q    <= '0;
      fill_q   <= '0;
      log2_q   <= '0;
      primed_q <= 1'b0;
      emit_q   <= 1'b0;
      tvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
      tdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      ptr_q    <= ptr_d;
      fill_q   <= fill_d;
      log2_q   <= log2_d;
      primed_q <= primed_d;
      emit_q   <= emit_d;
      tvalid_q <= tvalid_d;
      ovr_q    <= ovr_d;
      tdata_q  <= tdata_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign o_primed      = primed_q;
  assign o_overrun     = ovr_q;

endmodule
